// File: rtl/fpadd_sched_pkg.sv
// fpadd_sched_pkg: shared widths, the request/response bundles passed through
// the scheduler, and the saturating increment used by the statistics counters.
package fpadd_sched_pkg;

    localparam int FP_W   = 64;
    localparam int RM_W   = 3;
    localparam int OPT_W  = 3;
    localparam int FLG_W  = 5;
    localparam int STAT_W = 32;

    // Everything the fpadd needs for one operation, captured at accept.
    typedef struct packed {
        logic [FP_W-1:0]  op1;
        logic [FP_W-1:0]  op2;
        logic [RM_W-1:0]  rm;
        logic [OPT_W-1:0] op_type;
        logic             p;
        logic             oven;
        logic             unen;
    } fp_req_t;

    // Everything the fpadd returns, passed to the response channel untouched.
    typedef struct packed {
        logic [FP_W-1:0]  result;
        logic [FLG_W-1:0] flags;
        logic             denorm;
    } fp_resp_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/fpadd_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter. The requester just after ptr
// has the highest priority and the search wraps modulo N. Produces a one-hot
// grant plus the encoded winner index; both are zero when nothing requests.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] id
);

    logic [IDW-1:0] idx;

    // Scan from lowest to highest priority so the hit closest to ptr+1 is the last one written.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        grant = '0;
        id    = '0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            // NOTE: blocking assignments inside combinational logic take effect immediately, so a later iteration overrides an earlier one.
            idx = IDW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                id         = idx;
            end
        end
    end

endmodule

// File: rtl/fpadd_sched.sv
// fpadd_sched: shares one combinational fpadd between NREQ requesters.
// S1 (operand register) drives fa_*, S2 (result register) drives resp_*.
// Both stages move together whenever the response slot is empty or drained.
// Define FPADD_SCHED_STATS_EN to add the stat_issued / stat_stall counters.
module fpadd_sched
    import fpadd_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0][FP_W-1:0]   req_op1,
    input  logic [NREQ-1:0][FP_W-1:0]   req_op2,
    input  logic [NREQ-1:0][RM_W-1:0]   req_rm,
    input  logic [NREQ-1:0][OPT_W-1:0]  req_op_type,
    input  logic [NREQ-1:0]             req_p,
    input  logic                        cfg_oven,
    input  logic                        cfg_unen,
    output logic [FP_W-1:0]             fa_op1,
    output logic [FP_W-1:0]             fa_op2,
    output logic [RM_W-1:0]             fa_rm,
    output logic [OPT_W-1:0]            fa_op_type,
    output logic                        fa_p,
    output logic                        fa_oven,
    output logic                        fa_unen,
    input  logic [FP_W-1:0]             fa_result,
    input  logic [FLG_W-1:0]            fa_flags,
    input  logic                        fa_denorm,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [IDW-1:0]              resp_id,
    output logic [FP_W-1:0]             resp_result,
    output logic [FLG_W-1:0]            resp_flags,
    output logic                        resp_denorm
`ifdef FPADD_SCHED_STATS_EN
    ,
    output logic [NREQ-1:0][STAT_W-1:0] stat_issued,
    output logic [STAT_W-1:0]           stat_stall
`endif
);

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            advance;
    logic            accept;

    logic            s1_valid_q, s1_valid_d;
    fp_req_t         s1_req_q,   s1_req_d;
    logic [IDW-1:0]  s1_id_q,    s1_id_d;
    logic            s2_valid_q, s2_valid_d;
    fp_resp_t        s2_resp_q,  s2_resp_d;
    logic [IDW-1:0]  s2_id_q,    s2_id_d;
    logic [IDW-1:0]  ptr_q,      ptr_d;

    rr_arbiter #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .id    (grant_id)
    );

    // Pipe moves when the response slot is empty or being drained; ready is held low during reset.
    always_comb begin
        advance   = !s2_valid_q || resp_ready;
        accept    = advance && (|req_valid);
        req_ready = reset ? '0 : (grant & {NREQ{advance}});
    end

    // Next state of both stages and the round-robin pointer; everything holds on a stall.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_req_d   = s1_req_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_resp_d  = s2_resp_q;
        s2_id_d    = s2_id_q;
        ptr_d      = ptr_q;
        if (advance) begin
            // S1 payload (and therefore fa_*) only changes on an accept; a bubble clears the valid only.
            s1_valid_d = accept;
            if (accept) begin
                s1_req_d = '{op1:     req_op1[grant_id],
                             op2:     req_op2[grant_id],
                             rm:      req_rm[grant_id],
                             op_type: req_op_type[grant_id],
                             p:       req_p[grant_id],
                             oven:    cfg_oven,
                             unen:    cfg_unen};
                s1_id_d  = grant_id;
                ptr_d    = grant_id;
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_resp_d = '{result: fa_result, flags: fa_flags, denorm: fa_denorm};
                s2_id_d   = s1_id_q;
            end
        end
    end

    // Stage registers; the pointer resets to NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking assignments make every flop sample its _d at the same edge regardless of statement order.
            s1_valid_q <= 1'b0;
            s1_req_q   <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_resp_q  <= '0;
            s2_id_q    <= '0;
            ptr_q      <= IDW'(NREQ - 1);
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_req_q   <= s1_req_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_resp_q  <= s2_resp_d;
            s2_id_q    <= s2_id_d;
            ptr_q      <= ptr_d;
        end
    end

    assign fa_op1      = s1_req_q.op1;
    assign fa_op2      = s1_req_q.op2;
    assign fa_rm       = s1_req_q.rm;
    assign fa_op_type  = s1_req_q.op_type;
    assign fa_p        = s1_req_q.p;
    assign fa_oven     = s1_req_q.oven;
    assign fa_unen     = s1_req_q.unen;

    assign resp_valid  = s2_valid_q;
    assign resp_id     = s2_id_q;
    assign resp_result = s2_resp_q.result;
    assign resp_flags  = s2_resp_q.flags;
    assign resp_denorm = s2_resp_q.denorm;

`ifdef FPADD_SCHED_STATS_EN
    logic [NREQ-1:0][STAT_W-1:0] stat_issued_q, stat_issued_d;
    logic [STAT_W-1:0]           stat_stall_q,  stat_stall_d;

    // Saturating counts of accepts per requester and of cycles the response is blocked.
    always_comb begin
        stat_issued_d = stat_issued_q;
        stat_stall_d  = stat_stall_q;
        if (accept) begin
            stat_issued_d[grant_id] = sat_inc(stat_issued_q[grant_id]);
        end
        if (s2_valid_q && !resp_ready) begin
            stat_stall_d = sat_inc(stat_stall_q);
        end
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_fpadd_sched.sv
// tb_fpadd_sched: self-checking bench for fpadd_sched. A stand-in fpadd adds
// the operands as doubles and folds the control fields into result/flags so
// any misrouted field shows up. A transaction-level reference model predicts
// grants, fa_* contents and responses. Define FPADD_SCHED_STATS_EN to also
// exercise the statistics counters.
module tb_fpadd_sched;
    import fpadd_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0][FP_W-1:0]  req_op1, req_op2;
    logic [NREQ-1:0][RM_W-1:0]  req_rm;
    logic [NREQ-1:0][OPT_W-1:0] req_op_type;
    logic [NREQ-1:0]            req_p;
    logic                       cfg_oven, cfg_unen;
    logic [FP_W-1:0]            fa_op1, fa_op2;
    logic [RM_W-1:0]            fa_rm;
    logic [OPT_W-1:0]           fa_op_type;
    logic                       fa_p, fa_oven, fa_unen;
    logic [FP_W-1:0]            fa_result;
    logic [FLG_W-1:0]           fa_flags;
    logic                       fa_denorm;
    logic                       resp_valid, resp_ready;
    logic [IDW-1:0]             resp_id;
    logic [FP_W-1:0]            resp_result;
    logic [FLG_W-1:0]           resp_flags;
    logic                       resp_denorm;
`ifdef FPADD_SCHED_STATS_EN
    logic [NREQ-1:0][STAT_W-1:0] stat_issued;
    logic [STAT_W-1:0]           stat_stall;
`endif

    always #5 clk = ~clk;

    // Stand-in fpadd: true double addition, control fields folded into the outputs.
    function automatic fp_resp_t fpadd_ref(input fp_req_t r);
        fp_resp_t o;
        o.result = $realtobits($bitstoreal(r.op1) + $bitstoreal(r.op2))
                 ^ {55'd0, r.op_type, r.rm, r.p, r.oven, r.unen};
        o.flags  = {r.oven, r.unen, r.rm} ^ {r.op_type, r.p, 1'b0};
        o.denorm = r.p ^ r.op_type[0];
        return o;
    endfunction

    fp_req_t  fa_bus;
    fp_resp_t fa_out;
    fp_resp_t resp_bus;
    assign fa_bus    = {fa_op1, fa_op2, fa_rm, fa_op_type, fa_p, fa_oven, fa_unen};
    assign fa_out    = fpadd_ref(fa_bus);
    assign fa_result = fa_out.result;
    assign fa_flags  = fa_out.flags;
    assign fa_denorm = fa_out.denorm;
    assign resp_bus  = {resp_result, resp_flags, resp_denorm};

    fpadd_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op1     (req_op1),
        .req_op2     (req_op2),
        .req_rm      (req_rm),
        .req_op_type (req_op_type),
        .req_p       (req_p),
        .cfg_oven    (cfg_oven),
        .cfg_unen    (cfg_unen),
        .fa_op1      (fa_op1),
        .fa_op2      (fa_op2),
        .fa_rm       (fa_rm),
        .fa_op_type  (fa_op_type),
        .fa_p        (fa_p),
        .fa_oven     (fa_oven),
        .fa_unen     (fa_unen),
        .fa_result   (fa_result),
        .fa_flags    (fa_flags),
        .fa_denorm   (fa_denorm),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_flags  (resp_flags),
        .resp_denorm (resp_denorm)
`ifdef FPADD_SCHED_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall)
`endif
    );

    // ---------------- reference model (transaction level) ----------------
    bit             m_s1v, m_s2v;      // an op is at the fpadd inputs / a response is offered
    fp_req_t        m_s1;              // last op handed to the fpadd
    fp_resp_t       m_s2;              // response currently offered
    logic [IDW-1:0] m_s1id, m_s2id;
    int             m_ptr;             // last granted requester
    longint         m_issued[NREQ];
    longint         m_stall;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    function automatic fp_req_t req_of(input int i);
        return '{op1: req_op1[i], op2: req_op2[i], rm: req_rm[i], op_type: req_op_type[i],
                 p: req_p[i], oven: cfg_oven, unen: cfg_unen};
    endfunction

    function automatic int model_winner();
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] model_ready();
        logic [NREQ-1:0] r;
        int w;
        r = '0;
        w = model_winner();
        if (!reset && (!m_s2v || resp_ready) && w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_s1v = 0; m_s2v = 0; m_s1 = '0; m_s2 = '0; m_s1id = '0; m_s2id = '0;
        m_ptr = NREQ - 1; m_stall = 0;
        for (int i = 0; i < NREQ; i++) m_issued[i] = 0;
    endtask

    task automatic model_edge();
        int w;
        w = model_winner();
        if (m_s2v && !resp_ready) m_stall++;
        if (!m_s2v || resp_ready) begin
            if (m_s1v) begin
                m_s2   = fpadd_ref(m_s1);
                m_s2id = m_s1id;
            end
            m_s2v = m_s1v;
            m_s1v = (w >= 0);
            if (w >= 0) begin
                m_s1   = req_of(w);
                m_s1id = IDW'(w);
                m_ptr  = w;
                m_issued[w]++;
            end
        end
    endtask

    // Advance one clock; inputs are stable around the posedge, the model steps with it.
    task automatic tick();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [63:0] rand_op();
        return $realtobits(real'($urandom_range(0, 1 << 20)) / 256.0);
    endfunction

    task automatic randomize_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_op1[i]     = rand_op();
            req_op2[i]     = rand_op();
            req_rm[i]      = 3'($urandom);
            req_op_type[i] = 3'($urandom);
            req_p[i]       = 1'($urandom);
        end
        cfg_oven = 1'($urandom);
        cfg_unen = 1'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        req_valid = '0; resp_ready = 1'b0; cfg_oven = 0; cfg_unen = 0;
        req_op1 = '0; req_op2 = '0; req_rm = '0; req_op_type = '0; req_p = '0;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        n_vec++;
        if (resp_valid !== 1'b0 || resp_id !== '0 || resp_bus !== '0) begin
            n_err++; $display("FAIL reset_resp got v=%0b id=%0d %h want all zero", resp_valid, resp_id, resp_bus);
        end
        n_vec++;
        if (fa_bus !== '0) begin
            n_err++; $display("FAIL reset_fa got %h want 0", fa_bus);
        end
        req_valid = '1;
        #1;
        n_vec++;
        if (req_ready !== '0) begin
            n_err++; $display("FAIL reset_ready got %b want 0000", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        cyc++;
    endtask

    task automatic test_single_op();
        resp_ready = 1'b1; cfg_oven = 0; cfg_unen = 0;
        req_op1[0] = 64'h3FF0000000000000; req_op2[0] = 64'h4000000000000000;
        req_rm[0] = 3'd0; req_op_type[0] = 3'd0; req_p[0] = 1'b0;
        req_valid = 4'b0001;
        #1;
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++; $display("FAIL single_ready got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        n_vec++;
        if (fa_op1 !== 64'h3FF0000000000000 || fa_op2 !== 64'h4000000000000000 || resp_valid !== 1'b0) begin
            n_err++; $display("FAIL single_stage1 got op1=%h op2=%h rv=%0b want 3ff0.. 4000.. rv=0", fa_op1, fa_op2, resp_valid);
        end
        tick();
        #1;
        n_vec++;
        if (resp_valid !== 1'b1 || resp_result !== 64'h4008000000000000 || resp_flags !== 5'b00000 || resp_id !== 2'd0) begin
            n_err++; $display("FAIL single_resp got v=%0b r=%h f=%b id=%0d want v=1 r=4008000000000000 f=00000 id=0",
                              resp_valid, resp_result, resp_flags, resp_id);
        end
        tick();
        #1;
        n_vec++;
        if (resp_valid !== 1'b0) begin
            n_err++; $display("FAIL single_nodup got rv=%0b want 0", resp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_g;
        do_reset();
        resp_ready = 1'b1;
        req_valid  = '1;
        for (int c = 0; c < 8; c++) begin
            randomize_reqs();
            #1;
            exp_g = NREQ'(1) << (c % NREQ);
            n_vec++;
            if (req_ready !== exp_g) begin
                n_err++; $display("FAIL rr_grant c=%0d got %b want %b", c, req_ready, exp_g);
            end
            n_vec++;
            if (resp_valid !== m_s2v || (m_s2v && (resp_id !== m_s2id || resp_bus !== m_s2))) begin
                n_err++; $display("FAIL rr_resp cyc=%0d got v=%0b id=%0d %h want v=%0b id=%0d %h",
                                  cyc, resp_valid, resp_id, resp_bus, m_s2v, m_s2id, m_s2);
            end
            if (c >= 2) begin
                n_vec++;
                if (resp_valid !== 1'b1 || resp_id !== IDW'((c - 2) % NREQ)) begin
                    n_err++; $display("FAIL rr_order c=%0d got v=%0b id=%0d want v=1 id=%0d", c, resp_valid, resp_id, (c - 2) % NREQ);
                end
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_back_to_back_stall();
        fp_resp_t       held_resp;
        logic [IDW-1:0] held_id;
        fp_req_t        held_fa;
        int             got[$];
        do_reset();
        resp_ready = 1'b1;
        randomize_reqs();
        req_valid = 4'b0111;
        tick();
        tick();
        // op0 offered, op1 at the fpadd, op2 waiting at the port
        req_valid  = 4'b0100;
        resp_ready = 1'b0;
        held_resp = m_s2; held_id = m_s2id; held_fa = m_s1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            if (req_ready !== '0) begin
                n_err++; $display("FAIL bp_ready c=%0d got %b want 0000", c, req_ready);
            end
            n_vec++;
            if (resp_valid !== 1'b1 || resp_id !== held_id || resp_bus !== held_resp || fa_bus !== held_fa) begin
                n_err++; $display("FAIL bp_hold c=%0d got v=%0b id=%0d %h fa=%h want v=1 id=%0d %h fa=%h",
                                  c, resp_valid, resp_id, resp_bus, fa_bus, held_id, held_resp, held_fa);
            end
            req_op1[2] = rand_op();
            tick();
        end
        resp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_vec++;
            if (resp_valid !== m_s2v || (m_s2v && (resp_id !== m_s2id || resp_bus !== m_s2))) begin
                n_err++; $display("FAIL bp_resp cyc=%0d got v=%0b id=%0d %h want v=%0b id=%0d %h",
                                  cyc, resp_valid, resp_id, resp_bus, m_s2v, m_s2id, m_s2);
            end
            if (resp_valid === 1'b1) got.push_back(int'(resp_id));
            tick();
            req_valid = '0;
        end
        n_vec++;
        if (got.size() != 3 || got[0] != 0 || got[1] != 1 || got[2] != 2) begin
            n_err++; $display("FAIL bp_order got n=%0d ids=%p want n=3 ids 0 1 2", got.size(), got);
        end
    endtask

    task automatic test_sparse();
        int got_resp;
        longint start_acc;
        got_resp  = 0;
        start_acc = m_issued[2];
        resp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            req_valid = (c < 16 && c % 2 == 0) ? 4'b0100 : 4'b0000;
            randomize_reqs();
            #1;
            n_vec++;
            if (req_ready !== model_ready()) begin
                n_err++; $display("FAIL sparse_ready cyc=%0d got %b want %b", cyc, req_ready, model_ready());
            end
            n_vec++;
            if (resp_valid !== m_s2v || (m_s2v && (resp_id !== m_s2id || resp_bus !== m_s2))) begin
                n_err++; $display("FAIL sparse_resp cyc=%0d got v=%0b id=%0d %h want v=%0b id=%0d %h",
                                  cyc, resp_valid, resp_id, resp_bus, m_s2v, m_s2id, m_s2);
            end
            if (resp_valid === 1'b1) got_resp++;
            tick();
        end
        n_vec++;
        if (got_resp != 8 || m_issued[2] - start_acc != 8) begin
            n_err++; $display("FAIL sparse_count got resp=%0d want 8 (accepts %0d)", got_resp, m_issued[2] - start_acc);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid  = NREQ'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            randomize_reqs();
            #1;
            n_vec++;
            if (req_ready !== model_ready()) begin
                n_err++; $display("FAIL rand_ready cyc=%0d got %b want %b", cyc, req_ready, model_ready());
            end
            n_vec++;
            if (resp_valid !== m_s2v || (m_s2v && (resp_id !== m_s2id || resp_bus !== m_s2))) begin
                n_err++; $display("FAIL rand_resp cyc=%0d got v=%0b id=%0d %h want v=%0b id=%0d %h",
                                  cyc, resp_valid, resp_id, resp_bus, m_s2v, m_s2id, m_s2);
            end
            n_vec++;
            if (fa_bus !== m_s1) begin
                n_err++; $display("FAIL rand_fa cyc=%0d got %h want %h", cyc, fa_bus, m_s1);
            end
            tick();
        end
`ifdef FPADD_SCHED_STATS_EN
        #1;
        for (int i = 0; i < NREQ; i++) begin
            n_vec++;
            if (stat_issued[i] !== 32'(m_issued[i])) begin
                n_err++; $display("FAIL rand_stat_issued[%0d] got %0d want %0d", i, stat_issued[i], m_issued[i]);
            end
        end
        n_vec++;
        if (stat_stall !== 32'(m_stall)) begin
            n_err++; $display("FAIL rand_stat_stall got %0d want %0d", stat_stall, m_stall);
        end
`endif
        req_valid = '0;
    endtask

    task automatic test_reset_mid_op();
        resp_ready = 1'b1;
        randomize_reqs();
        req_valid = '1;
        tick();
        tick();
        // both stages hold ops now (model m_s1v and m_s2v are set)
        reset = 1'b1;
        #1;
        n_vec++;
        if (resp_valid !== 1'b0 || fa_bus !== '0 || req_ready !== '0) begin
            n_err++; $display("FAIL midrst_clear got rv=%0b fa=%h rdy=%b want rv=0 fa=0 rdy=0000 (model had s1=%0b s2=%0b)",
                              resp_valid, fa_bus, req_ready, m_s1v, m_s2v);
        end
        model_reset();
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        randomize_reqs();
        req_valid = 4'b1001;
        #1;
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++; $display("FAIL midrst_grant got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        n_vec++;
        if (fa_op1 !== req_op1[0] || fa_op2 !== req_op2[0] || fa_bus !== m_s1) begin
            n_err++; $display("FAIL midrst_fa got %h want %h", fa_bus, m_s1);
        end
        tick();
        tick();
    endtask

`ifdef FPADD_SCHED_STATS_EN
    task automatic test_stats();
        do_reset();
        resp_ready = 1'b1;
        req_valid  = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            randomize_reqs();
            tick();
        end
        req_valid  = '0;
        resp_ready = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        resp_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        #1;
        n_vec++;
        if (stat_issued[1] !== 32'd5 || stat_issued[0] !== 32'd0 || stat_issued[2] !== 32'd0 || stat_issued[3] !== 32'd0) begin
            n_err++; $display("FAIL stats_issued got %0d %0d %0d %0d want 0 5 0 0",
                              stat_issued[0], stat_issued[1], stat_issued[2], stat_issued[3]);
        end
        n_vec++;
        if (stat_stall !== 32'd4) begin
            n_err++; $display("FAIL stats_stall got %0d want 4", stat_stall);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_back_to_back_stall();
        test_sparse();
        test_random();
        test_reset_mid_op();
`ifdef FPADD_SCHED_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
